// File: rtl/text_console_writer.sv
// Teletype-style byte stream to text-area command words.
// Tracks cursor and scroll origin; clears exposed lines and the full screen.
module text_console_writer #(
  parameter int VIS_COLS = 80,
  parameter int VIS_ROWS = 60,
  parameter int BUF_COLS = 84,
  parameter int BUF_ROWS = 64
) (
  input  logic        i_cmd_clk,
  input  logic        i_rst,
  input  logic        i_char_valid,
  input  logic [7:0]  i_char,
  input  logic [7:0]  i_attr,
  output logic        o_char_ready,
  input  logic        i_clear,
  output logic        o_busy,
  output logic [5:0]  o_cursor_row,
  output logic [6:0]  o_cursor_col,
  output logic [31:0] o_cmd_data
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_PUT_CUR    = 4'd1;
  localparam logic [3:0] S_PUT_CELL   = 4'd2;
  localparam logic [3:0] S_SCROLL     = 4'd3;
  localparam logic [3:0] S_LCLR_CUR   = 4'd4;
  localparam logic [3:0] S_LCLR_CELL  = 4'd5;
  localparam logic [3:0] S_CLR_SCROLL = 4'd6;
  localparam logic [3:0] S_CCLR_CUR   = 4'd7;
  localparam logic [3:0] S_CCLR_CELL  = 4'd8;

  localparam logic [5:0] LP_RMAX = 6'(BUF_ROWS - 1);
  localparam logic [6:0] LP_CMAX = 7'(BUF_COLS - 1);
  localparam logic [6:0] LP_VMAX = 7'(VIS_COLS - 1);
  localparam logic [7:0] LP_SPC  = 8'h20;

  logic [3:0]  r_state;
  logic [31:0] r_cmd;
  logic [5:0]  r_row, r_top, r_crow;
  logic [6:0]  r_col, r_wcol, r_ccol;
  logic [7:0]  r_ch, r_attr;
  logic        r_bs;

  logic [5:0] w_nrow, w_ntop, w_bot;
  logic [6:0] w_sum;
  logic       w_scr, w_prt, w_cr, w_lf, w_bs;

  function automatic logic [5:0] f_rinc(input logic [5:0] r);
    return (r == LP_RMAX) ? 6'd0 : r + 6'd1;
  endfunction

  function automatic logic [31:0] f_cur(input logic [5:0] r,
                                        input logic [6:0] c);
    return {4'h7, 6'd0, r, 9'd0, c};
  endfunction

  function automatic logic [31:0] f_cell(input logic [7:0] a,
                                         input logic [7:0] ch);
    return {16'h8000, a, ch};
  endfunction

  function automatic logic [31:0] f_scr(input logic [5:0] t);
    return {4'h2, 19'd0, t, 3'd0};
  endfunction

  // Row just past the visible window; landing there forces a scroll.
  assign w_sum  = {1'b0, r_top} + 7'(VIS_ROWS);
  assign w_bot  = (w_sum >= 7'(BUF_ROWS)) ? 6'(w_sum - 7'(BUF_ROWS))
                                          : w_sum[5:0];
  assign w_nrow = f_rinc(r_row);
  assign w_ntop = f_rinc(r_top);
  assign w_scr  = (w_nrow == w_bot);

  assign w_prt = (i_char >= 8'h20);
  assign w_cr  = (i_char == 8'h0D);
  assign w_lf  = (i_char == 8'h0A);
  assign w_bs  = (i_char == 8'h08) && (r_col != 7'd0);

  always_ff @(posedge i_cmd_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_top   <= '0;
      r_crow  <= '0;
      r_ccol  <= '0;
      r_wcol  <= '0;
      r_ch    <= '0;
      r_attr  <= '0;
      r_bs    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd <= '0;
          if (i_clear) begin
            r_attr  <= i_attr;
            r_crow  <= '0;
            r_ccol  <= '0;
            r_cmd   <= f_scr(6'd0);
            r_state <= S_CLR_SCROLL;
          end else if (i_char_valid) begin
            r_attr <= i_attr;
            unique case (1'b1)
              w_prt: begin
                r_ch    <= i_char;
                r_bs    <= 1'b0;
                r_wcol  <= r_col;
                r_cmd   <= f_cur(r_row, r_col);
                r_state <= S_PUT_CUR;
              end
              w_bs: begin
                r_ch    <= LP_SPC;
                r_bs    <= 1'b1;
                r_wcol  <= r_col - 7'd1;
                r_cmd   <= f_cur(r_row, r_col - 7'd1);
                r_state <= S_PUT_CUR;
              end
              w_cr: r_col <= '0;
              w_lf: begin
                r_col <= '0;
                r_row <= w_nrow;
                if (w_scr) begin
                  r_top   <= w_ntop;
                  r_ccol  <= '0;
                  r_cmd   <= f_scr(w_ntop);
                  r_state <= S_SCROLL;
                end
              end
              default: ;
            endcase
          end
        end
        S_PUT_CUR: begin
          r_cmd   <= f_cell(r_attr, r_ch);
          r_state <= S_PUT_CELL;
        end
        S_PUT_CELL: begin
          r_cmd   <= '0;
          r_state <= S_IDLE;
          if (r_bs) begin
            r_col <= r_wcol;
          end else if (r_wcol == LP_VMAX) begin
            r_col <= '0;
            r_row <= w_nrow;
            if (w_scr) begin
              r_top   <= w_ntop;
              r_ccol  <= '0;
              r_cmd   <= f_scr(w_ntop);
              r_state <= S_SCROLL;
            end
          end else begin
            r_col <= r_wcol + 7'd1;
          end
        end
        S_SCROLL: begin
          r_cmd   <= f_cur(r_row, r_ccol);
          r_state <= S_LCLR_CUR;
        end
        S_LCLR_CUR: begin
          r_cmd   <= f_cell(r_attr, LP_SPC);
          r_state <= S_LCLR_CELL;
        end
        S_LCLR_CELL: begin
          if (r_ccol == LP_CMAX) begin
            r_cmd   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_ccol  <= r_ccol + 7'd1;
            r_cmd   <= f_cur(r_row, r_ccol + 7'd1);
            r_state <= S_LCLR_CUR;
          end
        end
        S_CLR_SCROLL: begin
          r_cmd   <= f_cur(r_crow, r_ccol);
          r_state <= S_CCLR_CUR;
        end
        S_CCLR_CUR: begin
          r_cmd   <= f_cell(r_attr, LP_SPC);
          r_state <= S_CCLR_CELL;
        end
        S_CCLR_CELL: begin
          if (r_ccol != LP_CMAX) begin
            r_ccol  <= r_ccol + 7'd1;
            r_cmd   <= f_cur(r_crow, r_ccol + 7'd1);
            r_state <= S_CCLR_CUR;
          end else if (r_crow != LP_RMAX) begin
            r_ccol  <= '0;
            r_crow  <= r_crow + 6'd1;
            r_cmd   <= f_cur(r_crow + 6'd1, 7'd0);
            r_state <= S_CCLR_CUR;
          end else begin
            r_row   <= '0;
            r_col   <= '0;
            r_top   <= '0;
            r_cmd   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cmd   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_char_ready = (r_state == S_IDLE) & ~i_clear;
  assign o_cursor_row = r_row;
  assign o_cursor_col = r_col;
  assign o_cmd_data   = r_cmd;

endmodule

// File: tb/tb_text_console_writer.sv
// Random and directed byte streams for text_console_writer,
// checked against a queue-based command-stream model.
module tb_text_console_writer;

  logic        i_cmd_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_char_valid = 1'b0;
  logic [7:0]  i_char = '0;
  logic [7:0]  i_attr = '0;
  logic        i_clear = 1'b0;
  logic        o_char_ready, o_busy;
  logic [5:0]  o_cursor_row;
  logic [6:0]  o_cursor_col;
  logic [31:0] o_cmd_data;

  int n_chk = 0;
  int n_err = 0;

  int m_row, m_col, m_top;
  logic [31:0] exp_q[$];

  text_console_writer dut (
    .i_cmd_clk    (i_cmd_clk),
    .i_rst        (i_rst),
    .i_char_valid (i_char_valid),
    .i_char       (i_char),
    .i_attr       (i_attr),
    .o_char_ready (o_char_ready),
    .i_clear      (i_clear),
    .o_busy       (o_busy),
    .o_cursor_row (o_cursor_row),
    .o_cursor_col (o_cursor_col),
    .o_cmd_data   (o_cmd_data)
  );

  always #5 i_cmd_clk = ~i_cmd_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cur_w(input int r, input int c);
    return 32'h70000000 + 32'(r) * 65536 + 32'(c);
  endfunction

  function automatic logic [31:0] cell_w(input logic [7:0] a,
                                         input logic [7:0] ch);
    return 32'h80000000 + 32'(a) * 256 + 32'(ch);
  endfunction

  function automatic void m_newline(input logic [7:0] a);
    m_row = (m_row + 1) % 64;
    if (m_row == (m_top + 60) % 64) begin
      m_top = (m_top + 1) % 64;
      exp_q.push_back(32'h20000000 + 32'(m_top * 8));
      for (int c = 0; c < 84; c++) begin
        exp_q.push_back(cur_w(m_row, c));
        exp_q.push_back(cell_w(a, 8'h20));
      end
    end
  endfunction

  function automatic void m_byte(input logic [7:0] ch, input logic [7:0] a);
    if (ch >= 8'h20) begin
      exp_q.push_back(cur_w(m_row, m_col));
      exp_q.push_back(cell_w(a, ch));
      if (m_col == 79) begin
        m_col = 0;
        m_newline(a);
      end else begin
        m_col++;
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      m_col = 0;
      m_newline(a);
    end else if (ch == 8'h08 && m_col > 0) begin
      m_col--;
      exp_q.push_back(cur_w(m_row, m_col));
      exp_q.push_back(cell_w(a, 8'h20));
    end
  endfunction

  function automatic void m_clear(input logic [7:0] a);
    exp_q.push_back(32'h20000000);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 84; c++) begin
        exp_q.push_back(cur_w(r, c));
        exp_q.push_back(cell_w(a, 8'h20));
      end
    m_row = 0;
    m_col = 0;
    m_top = 0;
  endfunction

  // Called #1 after an edge with the DUT idle; busy noise must be ignored.
  task automatic do_op(input bit clr, input logic [7:0] ch,
                       input logic [7:0] a);
    int k;
    chk("ready_pre", 32'(o_char_ready), 32'd1);
    if (clr) i_clear = 1'b1;
    else begin
      i_char_valid = 1'b1;
      i_char = ch;
    end
    i_attr = a;
    @(posedge i_cmd_clk); #1;
    i_clear = 1'b0;
    i_char_valid = 1'b0;
    exp_q.delete();
    if (clr) m_clear(a);
    else m_byte(ch, a);
    k = exp_q.size();
    for (int i = 0; i < k; i++) begin
      chk(clr ? "clr_cmd" : "cmd", o_cmd_data, exp_q[i]);
      chk("busy", 32'(o_busy), 32'd1);
      i_char_valid = 1'($urandom_range(0, 1));
      i_char = 8'($urandom);
      i_attr = 8'($urandom);
      i_clear = 1'($urandom_range(0, 1));
      @(posedge i_cmd_clk); #1;
    end
    i_char_valid = 1'b0;
    i_clear = 1'b0;
    #1;
    chk("idle_cmd", o_cmd_data, 32'd0);
    chk("ready_post", 32'(o_char_ready), 32'd1);
    chk("busy_post", 32'(o_busy), 32'd0);
    chk("row", 32'(o_cursor_row), 32'(m_row));
    chk("col", 32'(o_cursor_col), 32'(m_col));
  endtask

  function automatic logic [7:0] rand_byte();
    int p;
    logic [7:0] b;
    p = $urandom_range(0, 99);
    if (p < 60) b = 8'($urandom_range(32, 255));
    else if (p < 72) b = 8'h0A;
    else if (p < 80) b = 8'h0D;
    else if (p < 90) b = 8'h08;
    else begin
      b = 8'($urandom_range(0, 31));
      if (b == 8'h08 || b == 8'h0A || b == 8'h0D) b = 8'h1B;
    end
    return b;
  endfunction

  initial begin
    m_row = 0;
    m_col = 0;
    m_top = 0;
    #2;
    chk("rst_cmd", o_cmd_data, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_char_ready), 32'd1);
    repeat (2) @(posedge i_cmd_clk);
    #1 i_rst = 1'b0;
    @(posedge i_cmd_clk); #1;
    chk("rst_row", 32'(o_cursor_row), 32'd0);
    chk("rst_col", 32'(o_cursor_col), 32'd0);

    do_op(1'b0, 8'h41, 8'h1F);
    repeat (3) do_op(1'b0, 8'h0A, 8'h07);
    for (int i = 0; i < 80; i++)
      do_op(1'b0, 8'($urandom_range(32, 255)), 8'h07);
    do_op(1'b0, 8'h08, 8'h07);
    for (int i = 0; i < 5; i++) do_op(1'b0, 8'h61, 8'h07);
    do_op(1'b0, 8'h08, 8'h4E);

    do_op(1'b1, 8'h00, 8'h20);

    // Reset partway through a clear must truncate it immediately.
    i_clear = 1'b1;
    @(posedge i_cmd_clk); #1;
    i_clear = 1'b0;
    repeat (50) @(posedge i_cmd_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_cmd", o_cmd_data, 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_row", 32'(o_cursor_row), 32'd0);
    chk("mid_rst_col", 32'(o_cursor_col), 32'd0);
    chk("mid_rst_ready", 32'(o_char_ready), 32'd1);
    m_row = 0;
    m_col = 0;
    m_top = 0;
    @(posedge i_cmd_clk); #1;
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_cmd_clk); #1;
      chk("post_rst_nop", o_cmd_data, 32'd0);
    end

    for (int i = 0; i < 60; i++) do_op(1'b0, 8'h0A, 8'($urandom));
    for (int i = 0; i < 80; i++)
      do_op(1'b0, 8'($urandom_range(32, 255)), 8'($urandom));
    for (int i = 0; i < 300; i++) do_op(1'b0, rand_byte(), 8'($urandom));

    do_op(1'b1, 8'h00, 8'($urandom));
    for (int i = 0; i < 100; i++) do_op(1'b0, rand_byte(), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
